// File: rtl/mig_u_imem_resp.sv
// mig_u_imem_resp -- instruction memory responder.
//
// Word array with a synchronous read, followed by a 2-entry response FIFO.
// A request accepted in cycle T is read at the end of T. The read word sits in
// rd_insn/inflight_q during T+1 and is presented directly when the FIFO is
// empty, so the minimum latency is one cycle. A word that is not consumed in
// T+1 is pushed into the FIFO. A separate loader port writes the array at any
// time. Writes are read-first against a same-cycle read.
//
// Optional feature: define MIG_U_IMEM_RANGE_CHECK_EN to flag requests outside
// [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2) with rsp_err=1 and a NOP word.
// Without it, addresses wrap modulo the array depth and rsp_err is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     fetch request handshake, req_addr = word address
//   rsp_valid/ready     response handshake, rsp_insn/rsp_err = FIFO head
//   ld_we/addr/data     loader write port (word index)
module mig_u_imem_resp #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH_LOG2 = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:2] req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_insn,
   output logic                  rsp_err,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
   logic [ADDR_WIDTH-3:0] diff;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  accept, pop, push, fifo_pop, head_from_fifo;
   logic [1:0]            outstanding;

   // read register (the "in flight" word) and FIFO state
   logic [31:0] rd_insn;
   logic        inflight_q;
   logic [31:0] fifo_insn [0:1];
   logic [1:0]  fifo_count;
   logic        wr_ptr, rd_ptr;
   logic [31:0] head_insn;

   assign diff = req_addr - BASE_ADDR[ADDR_WIDTH-1:2];
   assign idx  = diff[DEPTH_LOG2-1:0];

`ifdef MIG_U_IMEM_RANGE_CHECK_EN
   logic       out_of_range;
   logic       rd_err;
   logic [1:0] fifo_err;
   logic       head_err;

   // unsigned offset from the base: anything at or beyond the depth,
   // including addresses below the base, is out of range
   assign out_of_range = |(diff >> DEPTH_LOG2);
`else
   // upper offset bits are intentionally ignored: addresses wrap
   logic unused_addr;
   assign unused_addr = ^diff;
`endif

   assign accept      = req_valid && req_ready;
   assign pop         = rsp_valid && rsp_ready;

   assign head_from_fifo = (fifo_count != 2'd0);
   assign rsp_valid      = head_from_fifo || inflight_q;

   // the in-flight word goes into the FIFO unless it is consumed directly
   assign push        = inflight_q && !(pop && !head_from_fifo);
   assign fifo_pop    = pop && head_from_fifo;

   assign outstanding = fifo_count + {1'b0, inflight_q};
   assign req_ready   = (outstanding < 2'd2) || pop;

   assign head_insn   = head_from_fifo ? fifo_insn[rd_ptr] : rd_insn;
   assign rsp_insn    = rsp_valid ? head_insn : 32'h0;

`ifdef MIG_U_IMEM_RANGE_CHECK_EN
   assign head_err = head_from_fifo ? fifo_err[rd_ptr] : rd_err;
   assign rsp_err  = rsp_valid && head_err;
`else
   assign rsp_err  = 1'b0;
`endif

   // Array and read register. The array has no reset.
   // Nonblocking read and write in the same block gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (!rst && ld_we)
         mem[ld_addr] <= ld_data;
      if (accept) begin
`ifdef MIG_U_IMEM_RANGE_CHECK_EN
         rd_insn <= out_of_range ? NOP : mem[idx];
         rd_err  <= out_of_range;
`else
         rd_insn <= mem[idx];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         fifo_count <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
      end else begin
         inflight_q <= accept;
         if (push) begin
            fifo_insn[wr_ptr] <= rd_insn;
`ifdef MIG_U_IMEM_RANGE_CHECK_EN
            fifo_err[wr_ptr]  <= rd_err;
`endif
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_pop)
            rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

endmodule

// File: tb/tb_mig_u_imem_resp.sv
// Testbench for mig_u_imem_resp.
// A table of scripted cycles and hand-written multi-cycle sequences run first.
// A randomized phase follows. Every cycle is also checked against a
// transaction-level reference model. The model is a queue of expected
// responses, and its array is written by the loader.
module tb_mig_u_imem_resp;
   localparam int          AW  = 32;
   localparam int          DL  = 10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          rsp_ready = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:2] req_addr = '0;
   logic [DL-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;
   logic          req_ready, rsp_valid, rsp_err;
   logic [31:0]   rsp_insn;

   always #5 clk = ~clk;

   mig_u_imem_resp #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .BASE_ADDR('0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_insn(rsp_insn), .rsp_err(rsp_err),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   typedef struct {
      logic [31:0] insn;
      logic        err;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [9:0]  la;
      logic [31:0] ld;
      logic        rv;
      logic [29:0] ra;
      logic        rr;
      logic        ev;
      logic [31:0] ei;
      logic        ee;
      logic        erdy;
   } vec_t;

   rsp_t        exp_q[$];
   logic [31:0] ref_mem [1024];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pre(input int i);
      if (i == 3) return 32'h0;
      if (i == 5) return 32'h00A0_0093;
      return {16'hC0DE, 16'(i * 7 + 1)};
   endfunction

   function automatic rsp_t model_read(input logic [29:0] wa);
      rsp_t r;
`ifdef MIG_U_IMEM_RANGE_CHECK_EN
      if (wa >= 30'd1024) begin
         r.insn = NOP;
         r.err  = 1'b1;
         return r;
      end
`endif
      r.insn = ref_mem[wa[9:0]];
      r.err  = 1'b0;
      return r;
   endfunction

   // mid-cycle: compare DUT outputs with the model
   task automatic mid();
      bit ev, er;
      @(negedge clk);
      ev = exp_q.size() > 0;
      er = (exp_q.size() < 2) || (ev && rsp_ready);
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("rsp_valid", 32'(rsp_valid), 32'(ev));
         if (ev && rsp_valid) begin
            chk("rsp_insn", rsp_insn, exp_q[0].insn);
            chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
         end
      end
   endtask

   // clock edge: advance the model with the inputs seen by the DUT
   task automatic adv();
      bit ev, er;
      ev = exp_q.size() > 0;
      er = (exp_q.size() < 2) || (ev && rsp_ready);
      @(posedge clk);
      if (rst) exp_q.delete();
      else begin
         if (ev && rsp_ready) void'(exp_q.pop_front());
         if (req_valid && er) exp_q.push_back(model_read(req_addr));
         if (ld_we) ref_mem[ld_addr] = ld_data;
      end
      #1;
   endtask

   task automatic cyc();
      mid();
      adv();
   endtask

   vec_t tv[7];
   int   nxt;

   initial begin
      // reset
      rst = 1'b1;
      adv();
      mid();
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      chk("reset rsp_insn", rsp_insn, 32'd0);
      adv();
      rst = 1'b0;
      chk_en = 1;
      mid();
      chk("post-reset req_ready", 32'(req_ready), 32'd1);
      adv();

      // preload words 0..31
      for (int i = 0; i < 32; i++) begin
         ld_we = 1'b1; ld_addr = 10'(i); ld_data = pre(i);
         cyc();
      end
      ld_we = 1'b0;

      // scripted cycles: basic fetch, read-first collision, out-of-range
      tv[0] = '{0, 0, 0,            1, 30'd5,     1, 0, 0,            0, 1};
      tv[1] = '{0, 0, 0,            0, 30'd0,     1, 1, 32'h00A00093, 0, 1};
      tv[2] = '{1, 3, 32'hDEADBEEF, 1, 30'd3,     1, 0, 0,            0, 1};
      tv[3] = '{0, 0, 0,            1, 30'd3,     1, 1, 32'h0,        0, 1};
      tv[4] = '{0, 0, 0,            1, 30'h400,   1, 1, 32'hDEADBEEF, 0, 1};
`ifdef MIG_U_IMEM_RANGE_CHECK_EN
      tv[5] = '{0, 0, 0,            0, 30'd0,     1, 1, NOP,          1, 1};
`else
      tv[5] = '{0, 0, 0,            0, 30'd0,     1, 1, pre(0),       0, 1};
`endif
      tv[6] = '{0, 0, 0,            0, 30'd0,     1, 0, 0,            0, 1};
      for (int i = 0; i < 7; i++) begin
         ld_we = tv[i].we; ld_addr = tv[i].la; ld_data = tv[i].ld;
         req_valid = tv[i].rv; req_addr = tv[i].ra; rsp_ready = tv[i].rr;
         mid();
         chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].ev));
         chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tv[i].erdy));
         if (tv[i].ev) begin
            chk($sformatf("vec%0d rsp_insn", i), rsp_insn, tv[i].ei);
            chk($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(tv[i].ee));
         end
         adv();
      end
      ld_we = 1'b0;

      // 8 back-to-back fetches, one response per cycle
      rsp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         req_valid = (i < 8); req_addr = 30'(8 + i);
         mid();
         if (i < 8) chk("b2b req_ready", 32'(req_ready), 32'd1);
         if (i >= 1) begin
            chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
            chk("b2b rsp_insn", rsp_insn, pre(8 + i - 1));
         end
         adv();
      end

      // backpressure: only 2 accepted, head stable, then drain and resume
      rsp_ready = 1'b0; nxt = 0;
      for (int c = 0; c < 5; c++) begin
         req_valid = 1'b1; req_addr = 30'(16 + nxt);
         mid();
         chk("bp req_ready", 32'(req_ready), 32'(c < 2));
         if (c >= 1) chk("bp rsp_insn stable", rsp_insn, pre(16));
         if (c < 2) nxt++;
         adv();
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      mid(); chk("drain 0", rsp_insn, pre(16)); adv();
      mid(); chk("drain 1", rsp_insn, pre(17)); adv();
      mid(); chk("drain empty", 32'(rsp_valid), 32'd0); adv();
      req_valid = 1'b1; req_addr = 30'd18; cyc();
      req_addr = 30'd19; cyc();
      req_valid = 1'b0; cyc(); cyc();

      // reset with 2 responses queued; loader write during reset is dropped
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 30'd20; cyc();
      req_addr = 30'd21; cyc();
      req_valid = 1'b0; cyc();
      rst = 1'b1; ld_we = 1'b1; ld_addr = 10'd7; ld_data = 32'hFFFF_FFFF;
      cyc();
      rst = 1'b0; ld_we = 1'b0;
      mid();
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_insn", rsp_insn, 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      adv();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mid(); chk("no stale rsp", 32'(rsp_valid), 32'd0); adv();
      end
      req_valid = 1'b1; req_addr = 30'd7; cyc();
      req_valid = 1'b0;
      mid(); chk("array kept over reset", rsp_insn, pre(7)); adv();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_addr  = ($urandom_range(0, 9) == 0) ? 30'(1024 + $urandom_range(0, 31))
                                                 : 30'($urandom_range(0, 31));
         ld_we     = ($urandom_range(0, 4) == 0);
         ld_addr   = 10'($urandom_range(0, 31));
         ld_data   = $urandom;
         cyc();
      end
      rst = 1'b0; req_valid = 1'b0; ld_we = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
